mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_stage_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared codes for the memory stage: RISC-V opcodes, load/store funct3 values,
// the NOP encoding, memory direction encodings and the FSM state type.
package mem_stage_ctrl_pkg;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [2:0]  F3_B      = 3'd0;
    localparam logic [2:0]  F3_H      = 3'd1;
    localparam logic [2:0]  F3_W      = 3'd2;
    localparam logic [2:0]  F3_D      = 3'd3;
    localparam logic [2:0]  F3_BU     = 3'd4;
    localparam logic [2:0]  F3_HU     = 3'd5;
    localparam logic [2:0]  F3_WU     = 3'd6;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic        MEM_READ  = 1'b0;
    localparam logic        MEM_WRITE = 1'b1;

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/byte enables into lanes,
// load data out of lanes with sign/zero extension, plus the alignment check.
module mem_lane_align
    import mem_stage_ctrl_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_offset,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_load_data,
    output logic             o_misalign
);
    logic [NB-1:0]    w_lanes;
    logic [OFF_W-1:0] w_amask;
    logic             w_sext;
    logic             w_bad;
    logic [XLEN-1:0]  w_keep;
    logic [XLEN-1:0]  w_shift;
    logic             w_neg;

    always_comb begin
        w_lanes = '0;
        w_amask = '0;
        w_sext  = 1'b0;
        w_bad   = 1'b0;
        w_keep  = '0;
        case (i_funct3)
            F3_B:  begin w_lanes = NB'(1);  w_sext = 1'b1; end
            F3_BU: begin w_lanes = NB'(1); end
            F3_H:  begin w_lanes = NB'(3);  w_amask = OFF_W'(1); w_sext = 1'b1; end
            F3_HU: begin w_lanes = NB'(3);  w_amask = OFF_W'(1); end
            F3_W:  begin w_lanes = NB'(15); w_amask = OFF_W'(3); w_sext = 1'b1; end
            F3_WU: begin w_lanes = NB'(15); w_amask = OFF_W'(3); end
            F3_D:  begin
                // Doubleword only exists on a 64-bit datapath
                if (NB == 8) begin
                    w_lanes = '1;
                    w_amask = OFF_W'(7);
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
        for (int i = 0; i < NB; i++) begin
            w_keep[8*i +: 8] = {8{w_lanes[i]}};
        end
    end

    assign w_shift     = i_rdata >> {i_offset, 3'b000};
    // Sign bit is the topmost kept bit of the right-aligned data
    assign w_neg       = w_sext && |(w_shift & w_keep & ~(w_keep >> 1));
    assign o_load_data = w_neg ? (w_shift | ~w_keep) : (w_shift & w_keep);
    assign o_be        = w_lanes << i_offset;
    assign o_wdata     = i_wdata << {i_offset, 3'b000};
    assign o_misalign  = w_bad || |(i_offset & w_amask);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage: accepts one instruction at a time, issues a held
// memory request for aligned loads/stores, and reports results or exceptions.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [31:0]         inst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ready,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall,
    output logic                out_valid,
    output logic [31:0]         inst_out,
    output logic [4:0]          rd,
    output logic [6:0]          opcode,
    output logic [XLEN-1:0]     load_data,
    output logic                misalign,
    output logic                bus_err
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_out_valid, r_misalign, r_bus_err;
    logic [31:0]       r_inst_out, r_inst;
    logic [4:0]        r_rd;
    logic [6:0]        r_opcode;
    logic [XLEN-1:0]   r_load_data;
    logic [2:0]        r_f3;
    logic [OFF_W-1:0]  r_off;

    logic              w_busy, w_is_mem, w_misalign, w_accept_mem;
    logic [2:0]        w_f3;
    logic [OFF_W-1:0]  w_off;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata, w_load;

    assign w_busy       = (r_state == BUSY);
    assign w_is_mem     = (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
    assign w_accept_mem = !w_busy && in_valid && w_is_mem && !w_misalign;
    // One lane aligner serves both directions: incoming fields while idle,
    // the captured access while waiting for read data
    assign w_f3         = w_busy ? r_f3  : inst[14:12];
    assign w_off        = w_busy ? r_off : addr[OFF_W-1:0];

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .i_funct3    (w_f3),
        .i_offset    (w_off),
        .i_wdata     (wdata),
        .i_rdata     (mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= MEM_READ;
            r_mem_be    <= '0;
            r_out_valid <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_inst_out  <= NOP;
            r_rd        <= '0;
            r_opcode    <= '0;
            r_load_data <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && (!w_is_mem || w_misalign)) begin
                        r_out_valid <= 1'b1;
                        r_misalign  <= w_is_mem;
                        r_inst_out  <= inst;
                        r_rd        <= inst[11:7];
                        r_opcode    <= inst[6:0];
                    end else if (w_accept_mem) begin
                        r_state   <= BUSY;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= (inst[6:0] == OP_STORE) ? MEM_WRITE : MEM_READ;
                        r_mem_be  <= w_be;
                    end
                end
                BUSY: begin
                    // A ready arriving on the final allowed cycle still completes cleanly
                    if (mem_ready || (r_cnt == CNT_W'(MAX_WAIT - 1))) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_bus_err   <= !mem_ready;
                        r_inst_out  <= r_inst;
                        r_rd        <= r_inst[11:7];
                        r_opcode    <= r_inst[6:0];
                        if (mem_ready && (r_inst[6:0] == OP_LOAD)) begin
                            r_load_data <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept_mem) begin
            r_mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_mem_wdata <= w_wdata;
            r_inst      <= inst;
            r_f3        <= inst[14:12];
            r_off       <= addr[OFF_W-1:0];
        end
    end

    assign stall     = w_busy;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign out_valid = r_out_valid;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;
    assign inst_out  = r_inst_out;
    assign rd        = r_rd;
    assign opcode    = r_opcode;
    assign load_data = r_load_data;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized loads/stores
// compared against an arithmetic model of lane selection and extension.
module tb_mem_stage_ctrl;
    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        stall, out_valid, misalign, bus_err;
    logic [31:0] inst_out;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] load_data;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_ld = 32'h0;

    mem_stage_ctrl #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .inst(inst), .addr(addr),
        .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .out_valid(out_valid),
        .inst_out(inst_out), .rd(rd), .opcode(opcode), .load_data(load_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        longint v;
        int     n;
        n = nbytes(f3);
        v = (longint'(w) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %h want 0", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %h want 0", mem_we); else passed++;
        total++; if (mem_be !== 4'h0) $display("FAIL rst_mem_be got %h want 0", mem_be); else passed++;
        total++; if ({out_valid, misalign, bus_err, stall} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {out_valid, misalign, bus_err, stall}); else passed++;
        total++; if (inst_out !== 32'h13) $display("FAIL rst_inst_out got %h want 00000013", inst_out); else passed++;
        total++; if ({rd, opcode} !== 12'h0) $display("FAIL rst_rd_opcode got %h want 0", {rd, opcode}); else passed++;
        total++; if (load_data !== 32'h0) $display("FAIL rst_load_data got %h want 0", load_data); else passed++;
        reset = 1'b0;
        exp_ld = 32'h0;
    endtask

    task automatic test_addi();
        inst = 32'h0050_0093; addr = 32'h0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL addi_out_valid got %b want 1", out_valid); else passed++;
        total++; if (inst_out !== 32'h0050_0093) $display("FAIL addi_inst_out got %h want 00500093", inst_out); else passed++;
        total++; if ({rd, opcode} !== {5'd1, 7'h13}) $display("FAIL addi_rd_op got %h want %h", {rd, opcode}, {5'd1, 7'h13}); else passed++;
        total++; if ({mem_req, stall, misalign} !== 3'b0) $display("FAIL addi_req_stall got %b want 000", {mem_req, stall, misalign}); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL addi_pulse got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_sb();
        inst = {7'h0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h23}; addr = 32'h103; wdata = 32'hAB; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if ({mem_req, mem_we, stall, out_valid} !== 4'b1110) $display("FAIL sb_ctrl[%0d] got %b want 1110", k, {mem_req, mem_we, stall, out_valid}); else passed++;
            total++; if ({mem_addr, mem_be, mem_wdata} !== {32'h100, 4'b1000, 32'hAB00_0000}) $display("FAIL sb_req[%0d] got %h/%h/%h want 100/8/ab000000", k, mem_addr, mem_be, mem_wdata); else passed++;
            if (k < 2) step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        total++; if ({out_valid, mem_req, stall, bus_err} !== 4'b1000) $display("FAIL sb_done got %b want 1000", {out_valid, mem_req, stall, bus_err}); else passed++;
        total++; if (load_data !== exp_ld) $display("FAIL sb_load_hold got %h want %h", load_data, exp_ld); else passed++;
        step();
    endtask

    task automatic test_lh();
        logic [2:0] f3s [2] = '{3'd1, 3'd5};
        logic [31:0] want [2] = '{32'hFFFF_8001, 32'h0000_8001};
        for (int t = 0; t < 2; t++) begin
            int st = 0;
            inst = {12'h0, 5'd1, f3s[t], 5'd5, 7'h03}; addr = 32'h102; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (stall) st++;
            total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) $display("FAIL lh_req[%0d] got %b/%b/%h want 1/0/100", t, mem_req, mem_we, mem_addr); else passed++;
            for (int k = 0; k < 3; k++) begin
                step();
                if (stall) st++;
            end
            mem_ready = 1'b1; mem_rdata = 32'h8001_1234;
            step();
            mem_ready = 1'b0;
            if (stall) st++;
            total++; if (st !== 4) $display("FAIL lh_stall_cycles[%0d] got %0d want 4", t, st); else passed++;
            total++; if ({out_valid, bus_err} !== 2'b10) $display("FAIL lh_done[%0d] got %b want 10", t, {out_valid, bus_err}); else passed++;
            total++; if (load_data !== want[t]) $display("FAIL lh_load_data[%0d] got %h want %h", t, load_data, want[t]); else passed++;
            exp_ld = want[t];
            step();
        end
    endtask

    task automatic test_misalign();
        inst = {12'h0, 5'd1, 3'd2, 5'd6, 7'h03}; addr = 32'h101; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, misalign, bus_err, mem_req, stall} !== 5'b11000) $display("FAIL misalign_pulse got %b want 11000", {out_valid, misalign, bus_err, mem_req, stall}); else passed++;
        step();
        total++; if ({out_valid, misalign, mem_req} !== 3'b000) $display("FAIL misalign_clear got %b want 000", {out_valid, misalign, mem_req}); else passed++;
    endtask

    task automatic test_timeout();
        inst = {12'h0, 5'd1, 3'd2, 5'd7, 7'h03}; addr = 32'h200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < MW; k++) begin
            total++; if ({mem_req, out_valid} !== 2'b10) $display("FAIL to_wait[%0d] got %b want 10", k, {mem_req, out_valid}); else passed++;
            step();
        end
        total++; if ({mem_req, out_valid, bus_err, stall} !== 4'b0110) $display("FAIL to_buserr got %b want 0110", {mem_req, out_valid, bus_err, stall}); else passed++;
        total++; if (load_data !== exp_ld) $display("FAIL to_load_hold got %h want %h", load_data, exp_ld); else passed++;
        step();
        total++; if ({out_valid, bus_err} !== 2'b00) $display("FAIL to_clear got %b want 00", {out_valid, bus_err}); else passed++;
        inst = {12'h0, 5'd1, 3'd2, 5'd7, 7'h03}; addr = 32'h204; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < MW - 1; k++) step();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ready = 1'b0;
        total++; if ({mem_req, out_valid, bus_err} !== 3'b010) $display("FAIL to_limit_ready got %b want 010", {mem_req, out_valid, bus_err}); else passed++;
        total++; if (load_data !== 32'h1234_5678) $display("FAIL to_limit_data got %h want 12345678", load_data); else passed++;
        exp_ld = 32'h1234_5678;
        step();
    endtask

    task automatic test_reset_busy();
        inst = {12'h0, 5'd1, 3'd2, 5'd8, 7'h03}; addr = 32'h300; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_ld = 32'h0;
        total++; if ({mem_req, out_valid, stall} !== 3'b000) $display("FAIL rb_abandon got %b want 000", {mem_req, out_valid, stall}); else passed++;
        total++; if (inst_out !== 32'h13) $display("FAIL rb_inst_out got %h want 00000013", inst_out); else passed++;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (out_valid !== 1'b0) $display("FAIL rb_no_valid[%0d] got %b want 0", k, out_valid); else passed++;
        end
        inst = {12'h0, 5'd1, 3'd2, 5'd9, 7'h03}; addr = 32'h304; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if ({mem_req, mem_addr} !== {1'b1, 32'h304}) $display("FAIL rb_lw_req got %b/%h want 1/304", mem_req, mem_addr); else passed++;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ready = 1'b0;
        total++; if ({out_valid, bus_err, load_data} !== {2'b10, 32'hCAFE_F00D}) $display("FAIL rb_lw_done got %b/%h want 10/cafef00d", {out_valid, bus_err}, load_data); else passed++;
        exp_ld = 32'hCAFE_F00D;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] i1 = 32'h0010_0113;
        logic [31:0] i2 = 32'h0020_0193;
        logic [31:0] i3 = 32'h0030_0213;
        inst = i1; in_valid = 1'b1;
        step();
        inst = i2;
        total++; if ({out_valid, inst_out} !== {1'b1, i1}) $display("FAIL b2b_first got %b/%h want 1/%h", out_valid, inst_out, i1); else passed++;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, inst_out, rd} !== {1'b1, i2, 5'd3}) $display("FAIL b2b_second got %b/%h/%h want 1/%h/3", out_valid, inst_out, rd, i2); else passed++;
        inst = {12'h0, 5'd1, 3'd0, 5'd4, 7'h03}; addr = 32'h401; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_7F00;
        step();
        mem_ready = 1'b0;
        inst = i3; in_valid = 1'b1;
        total++; if ({out_valid, load_data} !== {1'b1, 32'h7F}) $display("FAIL b2b_lb got %b/%h want 1/7f", out_valid, load_data); else passed++;
        exp_ld = 32'h7F;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, inst_out, stall} !== {1'b1, i3, 1'b0}) $display("FAIL b2b_after_load got %b/%h/%b want 1/%h/0", out_valid, inst_out, stall, i3); else passed++;
        step();
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int t = 0; t < 60; t++) begin
            logic [31:0] r, a, d, rdat, i, lanes;
            logic [6:0]  op;
            logic [2:0]  f3;
            int kind, waits, n, off;
            r = $urandom(); a = $urandom(); d = $urandom(); rdat = $urandom();
            kind = $urandom_range(0, 2);
            waits = $urandom_range(0, MW + 1);
            op = (kind == 0) ? 7'h13 : (kind == 1) ? 7'h03 : 7'h23;
            f3 = (kind == 0) ? 3'd0 : (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            i = {r[31:15], f3, r[11:7], op};
            n = nbytes(f3);
            off = int'(a % 4);
            lanes = 32'(((64'd1 << (8 * n)) - 1) << (8 * off));
            inst = i; addr = a; wdata = d; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (kind == 0) begin
                total++; if ({out_valid, inst_out, rd, opcode, mem_req, stall} !== {1'b1, i, r[11:7], op, 2'b00}) $display("FAIL rnd_alu[%0d] got %b/%h/%h/%h want 1/%h", t, out_valid, inst_out, rd, opcode, i); else passed++;
            end else if ((a % n) != 0) begin
                total++; if ({out_valid, misalign, mem_req, stall} !== 4'b1100) $display("FAIL rnd_misalign[%0d] got %b want 1100 (addr %h n %0d)", t, {out_valid, misalign, mem_req, stall}, a, n); else passed++;
            end else begin
                total++; if ({mem_req, mem_we, stall, out_valid} !== {1'b1, kind == 2, 2'b10}) $display("FAIL rnd_req[%0d] got %b want %b", t, {mem_req, mem_we, stall, out_valid}, {1'b1, kind == 2, 2'b10}); else passed++;
                total++; if ({mem_addr, mem_be} !== {a & 32'hFFFF_FFFC, 4'(((1 << n) - 1) << off)}) $display("FAIL rnd_addr_be[%0d] got %h/%h want %h/%h", t, mem_addr, mem_be, a & 32'hFFFF_FFFC, 4'(((1 << n) - 1) << off)); else passed++;
                if (kind == 2) begin
                    total++; if ((mem_wdata & lanes) !== ((d << (8 * off)) & lanes)) $display("FAIL rnd_wdata[%0d] got %h want %h", t, mem_wdata & lanes, (d << (8 * off)) & lanes); else passed++;
                end
                for (int k = 0; k < MW; k++) begin
                    if (k == waits) begin
                        mem_ready = 1'b1; mem_rdata = rdat;
                        step();
                        mem_ready = 1'b0;
                        break;
                    end
                    mem_rdata = $urandom();
                    step();
                    if (k < MW - 1) begin
                        total++; if ({mem_req, out_valid, mem_addr} !== {2'b10, a & 32'hFFFF_FFFC}) $display("FAIL rnd_hold[%0d.%0d] got %b/%h want 10/%h", t, k, {mem_req, out_valid}, mem_addr, a & 32'hFFFF_FFFC); else passed++;
                    end
                end
                if (waits < MW && kind == 1) exp_ld = model_load(f3, off, rdat);
                total++; if ({out_valid, bus_err, misalign, mem_req, stall} !== {1'b1, waits >= MW, 3'b000}) $display("FAIL rnd_done[%0d] got %b want %b", t, {out_valid, bus_err, misalign, mem_req, stall}, {1'b1, waits >= MW, 3'b000}); else passed++;
                total++; if (load_data !== exp_ld) $display("FAIL rnd_load_data[%0d] got %h want %h (f3 %0d off %0d rdata %h)", t, load_data, exp_ld, f3, off, rdat); else passed++;
            end
            step();
            total++; if ({out_valid, misalign, bus_err} !== 3'b000) $display("FAIL rnd_idle[%0d] got %b want 000", t, {out_valid, misalign, bus_err}); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sb();
        test_lh();
        test_misalign();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
